// File: rtl/key_event_gen_pkg.sv
// Shared definitions for the key event generator.
//   - key_state_t : per-key FSM state encoding (2-bit)
//   - NUM_KEYS    : number of independent keys handled by the block
//   - CNT_W       : width of the per-key hold counter
//   - sat_inc()   : saturating increment for the hold counter
package key_event_gen_pkg;

    localparam int NUM_KEYS = 4;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS    = 2'd1,
        ST_HOLD     = 2'd2,
        ST_WAIT_REL = 2'd3
    } key_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t CNT_MAX  = {CNT_W{1'b1}};

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t value);
        cnt_t result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Bus between the key event generator and its user.
//   en_tick      : 100 Hz one-clk enable strobe
//   key_db       : debounced key levels, 1 = pressed
//   short_pulse  : per-key pulse on release of a short press
//   long_pulse   : per-key pulse when the hold reaches the long-press time
//   repeat_pulse : per-key auto-repeat pulse while held after a long press
//   key_held     : per-key level, key is being pressed/held
//   any_event    : OR of all pulses
// Modport master drives the inputs and observes events; slave is the generator.
interface key_event_gen_if;
    import key_event_gen_pkg::*;

    logic                en_tick;
    logic [NUM_KEYS-1:0] key_db;
    logic [NUM_KEYS-1:0] short_pulse;
    logic [NUM_KEYS-1:0] long_pulse;
    logic [NUM_KEYS-1:0] repeat_pulse;
    logic [NUM_KEYS-1:0] key_held;
    logic                any_event;

    modport master (
        output en_tick, key_db,
        input  short_pulse, long_pulse, repeat_pulse, key_held, any_event
    );

    modport slave (
        input  en_tick, key_db,
        output short_pulse, long_pulse, repeat_pulse, key_held, any_event
    );

endinterface

// File: rtl/key_event_gen_cell.sv
// key_event_cell: press/hold/repeat FSM for a single key.
//   clk, rst     : clock and asynchronous active-low reset
//   en_tick      : 100 Hz enable strobe, advances the hold counter
//   key_db       : debounced level of this key
//   short_pulse  : one clk after release of a press shorter than LONG_TICKS
//   long_pulse   : one clk after the tick that completes LONG_TICKS of hold
//   repeat_pulse : one clk after every REPEAT_TICKS of further hold
//   key_held     : 1 while in PRESS or HOLD
// All outputs are registers; at most one pulse is set per clk.
module key_event_cell
    import key_event_gen_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en_tick,
    input  logic key_db,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    localparam cnt_t LONG_CNT   = cnt_t'(LONG_TICKS);
    localparam cnt_t REPEAT_CNT = cnt_t'(REPEAT_TICKS);

    key_state_t state_r;
    cnt_t       cnt_r;
    cnt_t       cnt_inc_s;
    logic       prev_r;
    logic       short_r;
    logic       long_r;
    logic       repeat_r;
    logic       held_r;

    assign cnt_inc_s = sat_inc(cnt_r);

    // Key FSM, hold counter, previous-sample register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            // Previous sample resets high so a key already down at reset
            // release is not mistaken for a fresh press.
            prev_r   <= 1'b1;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            held_r   <= 1'b0;
        end else begin
            prev_r   <= key_db;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (key_db && !prev_r) begin
                        state_r <= ST_PRESS;
                        cnt_r   <= CNT_ZERO;
                        held_r  <= 1'b1;
                    end else if (key_db) begin
                        // Only reachable when the key was down through reset.
                        state_r <= ST_WAIT_REL;
                        held_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        held_r  <= 1'b0;
                    end
                end
                ST_PRESS: begin
                    // Release wins over a coincident tick.
                    if (!key_db) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        short_r <= 1'b1;
                        held_r  <= 1'b0;
                    end else if (en_tick) begin
                        held_r <= 1'b1;
                        if (cnt_inc_s == LONG_CNT) begin
                            state_r <= ST_HOLD;
                            cnt_r   <= CNT_ZERO;
                            long_r  <= 1'b1;
                        end else begin
                            state_r <= ST_PRESS;
                            cnt_r   <= cnt_inc_s;
                        end
                    end else begin
                        state_r <= ST_PRESS;
                        held_r  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!key_db) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        held_r  <= 1'b0;
                    end else if (en_tick) begin
                        state_r <= ST_HOLD;
                        held_r  <= 1'b1;
                        if (cnt_inc_s == REPEAT_CNT) begin
                            cnt_r    <= CNT_ZERO;
                            repeat_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                        held_r  <= 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    held_r <= 1'b0;
                    if (!key_db) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_REL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    held_r  <= 1'b0;
                end
            endcase
        end
    end

    assign short_pulse  = short_r;
    assign long_pulse   = long_r;
    assign repeat_pulse = repeat_r;
    assign key_held     = held_r;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: four independent key event cells plus the any_event OR.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : key_event_gen_if.slave (en_tick, key_db in; pulses, key_held,
//         any_event out)
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic            clk,
    input  logic            rst,
    key_event_gen_if.slave  bus
);

    logic [NUM_KEYS-1:0] short_s;
    logic [NUM_KEYS-1:0] long_s;
    logic [NUM_KEYS-1:0] repeat_s;
    logic [NUM_KEYS-1:0] held_s;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cell
        key_event_cell #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en_tick      (bus.en_tick),
            .key_db       (bus.key_db[k]),
            .short_pulse  (short_s[k]),
            .long_pulse   (long_s[k]),
            .repeat_pulse (repeat_s[k]),
            .key_held     (held_s[k])
        );
    end

    assign bus.short_pulse  = short_s;
    assign bus.long_pulse   = long_s;
    assign bus.repeat_pulse = repeat_s;
    assign bus.key_held     = held_s;
    // OR of registered pulses, so it lines up with them cycle for cycle.
    assign bus.any_event    = |(short_s | long_s | repeat_s);

endmodule

// File: tb/tb_key_event_gen.sv
// Directed testbench for key_event_gen with LONG_TICKS=5, REPEAT_TICKS=2 and
// en_tick every 4 clocks.
module tb_key_event_gen;

    logic clk;
    logic rst;
    logic mon_clr;
    int   n_pass;
    int   n_total;
    int   n_any;
    logic [3:0] seen_short;
    logic [3:0] seen_long;
    logic [3:0] seen_rep;

    key_event_gen_if bus ();

    key_event_gen #(
        .LONG_TICKS   (5),
        .REPEAT_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Event monitor: accumulates pulses seen in the previous cycle.
    always @(posedge clk) begin
        if (mon_clr) begin
            n_any      <= 0;
            seen_short <= 4'b0000;
            seen_long  <= 4'b0000;
            seen_rep   <= 4'b0000;
        end else begin
            if (bus.any_event) n_any <= n_any + 1;
            seen_short <= seen_short | bus.short_pulse;
            seen_long  <= seen_long  | bus.long_pulse;
            seen_rep   <= seen_rep   | bus.repeat_pulse;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive en_tick for one clock; returns at the following negedge.
    task automatic run_clk(input logic tk);
        bus.en_tick = tk;
        @(negedge clk);
    endtask

    // Three idle clocks then one tick clock.
    task automatic tick_period();
        run_clk(1'b0);
        run_clk(1'b0);
        run_clk(1'b0);
        run_clk(1'b1);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        run_clk(1'b0);
        mon_clr = 1'b0;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b0;
        mon_clr     = 1'b1;
        bus.key_db  = 4'b0000;
        bus.en_tick = 1'b0;
        @(negedge clk);
        run_clk(1'b0);
        run_clk(1'b0);
        mon_clr = 1'b0;

        // Reset state
        chk("rst_held",   {4'h0, bus.key_held},     8'h00);
        chk("rst_short",  {4'h0, bus.short_pulse},  8'h00);
        chk("rst_long",   {4'h0, bus.long_pulse},   8'h00);
        chk("rst_repeat", {4'h0, bus.repeat_pulse}, 8'h00);
        chk("rst_any",    {7'h00, bus.any_event},   8'h00);
        rst = 1'b1;
        run_clk(1'b0);
        run_clk(1'b0);

        // A: short press of key 0 for 3 ticks
        bus.key_db = 4'b0001;
        run_clk(1'b0);
        chk("A_held", {4'h0, bus.key_held}, 8'h01);
        tick_period();
        tick_period();
        tick_period();
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        chk("A_short",   {4'h0, bus.short_pulse}, 8'h01);
        chk("A_any",     {7'h00, bus.any_event},  8'h01);
        chk("A_no_long", {4'h0, bus.long_pulse},  8'h00);
        chk("A_held_off", {4'h0, bus.key_held},   8'h00);
        run_clk(1'b0);
        chk("A_short_1clk", {4'h0, bus.short_pulse}, 8'h00);

        // B: key 1 held for 10 ticks
        clear_mon();
        bus.key_db = 4'b0010;
        run_clk(1'b0);
        for (int t = 1; t <= 4; t++) begin
            tick_period();
            chk("B_no_long_early", {4'h0, bus.long_pulse}, 8'h00);
        end
        tick_period();
        chk("B_long_t5", {4'h0, bus.long_pulse}, 8'h02);
        chk("B_held_t5", {4'h0, bus.key_held},   8'h02);
        run_clk(1'b0);
        chk("B_long_1clk", {4'h0, bus.long_pulse}, 8'h00);
        tick_period();
        chk("B_no_rep_t6", {4'h0, bus.repeat_pulse}, 8'h00);
        tick_period();
        chk("B_rep_t7", {4'h0, bus.repeat_pulse}, 8'h02);
        tick_period();
        chk("B_no_rep_t8", {4'h0, bus.repeat_pulse}, 8'h00);
        tick_period();
        chk("B_rep_t9", {4'h0, bus.repeat_pulse}, 8'h02);
        tick_period();
        chk("B_no_rep_t10", {4'h0, bus.repeat_pulse}, 8'h00);
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        chk("B_no_short_rel", {4'h0, bus.short_pulse}, 8'h00);
        chk("B_held_rel",     {4'h0, bus.key_held},    8'h00);
        run_clk(1'b0);
        run_clk(1'b0);
        chk("B_n_any",      8'(n_any),          8'h03);
        chk("B_seen_short", {4'h0, seen_short}, 8'h00);

        // C: all keys held through reset release, then short press of key 2
        rst = 1'b0;
        bus.key_db = 4'b1111;
        run_clk(1'b0);
        run_clk(1'b0);
        clear_mon();
        rst = 1'b1;
        for (int t = 1; t <= 6; t++) tick_period();
        chk("C_held_wait", {4'h0, bus.key_held}, 8'h00);
        chk("C_no_events", 8'(n_any),            8'h00);
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        run_clk(1'b0);
        chk("C_no_events_rel", 8'(n_any), 8'h00);
        bus.key_db = 4'b0100;
        run_clk(1'b0);
        chk("C_held_k2", {4'h0, bus.key_held}, 8'h04);
        tick_period();
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        chk("C_short_k2", {4'h0, bus.short_pulse}, 8'h04);
        run_clk(1'b0);
        run_clk(1'b0);
        chk("C_seen_short", {4'h0, seen_short}, 8'h04);
        chk("C_seen_long",  {4'h0, seen_long},  8'h00);
        chk("C_n_any",      8'(n_any),          8'h01);

        // D: key 3 released in the same clk as the 5th tick
        clear_mon();
        bus.key_db = 4'b1000;
        run_clk(1'b0);
        for (int t = 1; t <= 4; t++) tick_period();
        run_clk(1'b0);
        run_clk(1'b0);
        run_clk(1'b0);
        bus.key_db = 4'b0000;
        run_clk(1'b1);
        chk("D_short_k3", {4'h0, bus.short_pulse}, 8'h08);
        chk("D_no_long",  {4'h0, bus.long_pulse},  8'h00);
        run_clk(1'b0);
        run_clk(1'b0);
        chk("D_seen_long", {4'h0, seen_long}, 8'h00);
        chk("D_n_any",     8'(n_any),         8'h01);

        // E: reset at tick 4 of a key 0 press, released while still pressed
        clear_mon();
        bus.key_db = 4'b0001;
        run_clk(1'b0);
        for (int t = 1; t <= 4; t++) tick_period();
        rst = 1'b0;
        #1;
        chk("E_held_rst", {4'h0, bus.key_held}, 8'h00);
        run_clk(1'b0);
        run_clk(1'b0);
        rst = 1'b1;
        for (int t = 1; t <= 7; t++) tick_period();
        chk("E_held_after", {4'h0, bus.key_held}, 8'h00);
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        chk("E_no_short_rel", {4'h0, bus.short_pulse}, 8'h00);
        run_clk(1'b0);
        chk("E_n_any_none", 8'(n_any), 8'h00);
        bus.key_db = 4'b0001;
        run_clk(1'b0);
        tick_period();
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        chk("E_short_repress", {4'h0, bus.short_pulse}, 8'h01);

        // F: keys 0 and 1 together, key 0 for 2 ticks, key 1 for 6 ticks
        run_clk(1'b0);
        clear_mon();
        bus.key_db = 4'b0011;
        run_clk(1'b0);
        chk("F_held_both", {4'h0, bus.key_held}, 8'h03);
        tick_period();
        tick_period();
        bus.key_db = 4'b0010;
        run_clk(1'b0);
        chk("F_short_k0", {4'h0, bus.short_pulse}, 8'h01);
        tick_period();
        tick_period();
        chk("F_no_long_t4", {4'h0, bus.long_pulse}, 8'h00);
        tick_period();
        chk("F_long_k1", {4'h0, bus.long_pulse}, 8'h02);
        chk("F_any_long", {7'h00, bus.any_event}, 8'h01);
        tick_period();
        chk("F_no_rep_t6", {4'h0, bus.repeat_pulse}, 8'h00);
        bus.key_db = 4'b0000;
        run_clk(1'b0);
        chk("F_no_short_k1", {4'h0, bus.short_pulse}, 8'h00);
        run_clk(1'b0);
        run_clk(1'b0);
        chk("F_n_any",      8'(n_any),          8'h02);
        chk("F_seen_short", {4'h0, seen_short}, 8'h01);
        chk("F_seen_long",  {4'h0, seen_long},  8'h02);
        chk("F_seen_rep",   {4'h0, seen_rep},   8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 The block SHALL have parameter LONG_TICKS, default 100, meaning the number of en_tick pulses a key must be held before a long-press event (1 s at 100 Hz); legal range 2..255.
REQ-002 The block SHALL have parameter REPEAT_TICKS, default 20, meaning the number of en_tick pulses between auto-repeat events after a long press; legal range 1..255.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en_tick  input  1  one-clk enable pulse at 100 Hz (the en_100hz strobe).
REQ-006 key_db  input  4  debounced switch levels, 1 = pressed.
REQ-007 short_pulse  output  4  one-clk pulse per key on release of a short press.
REQ-008 long_pulse  output  4  one-clk pulse per key when the hold reaches LONG_TICKS.
REQ-009 repeat_pulse  output  4  one-clk pulse per key every REPEAT_TICKS while held after long_pulse.
REQ-010 key_held  output  4  level: key is in PRESS or HOLD state.
REQ-011 any_event  output  1  OR of all short, long and repeat pulses, same cycle.

Function
REQ-012 Each key SHALL be handled independently by an identical FSM; simultaneous activity on several keys SHALL NOT interact.
REQ-013 FSM states SHALL be IDLE, PRESS, HOLD and WAIT_REL.
REQ-014 IDLE->PRESS SHALL occur on the clk where key_db=1 and the registered previous sample=0; the hold counter SHALL be cleared on entry.
REQ-015 In PRESS the 8-bit hold counter SHALL increment on each en_tick while key_db=1.
REQ-016 PRESS->IDLE on key_db=0 SHALL assert short_pulse for exactly the next clk (1-cycle latency from the first low sample).
REQ-017 PRESS->HOLD SHALL occur on the en_tick that brings the counter to LONG_TICKS; long_pulse SHALL assert for the next clk and the counter SHALL clear.
REQ-018 In HOLD the counter SHALL increment per en_tick; reaching REPEAT_TICKS SHALL assert repeat_pulse for the next clk and clear the counter.
REQ-019 HOLD->IDLE on key_db=0 SHALL produce no pulse; a short press SHALL never follow a long press.
REQ-020 If key_db=1 at reset release, the FSM SHALL enter WAIT_REL and emit nothing until key_db=0, then go to IDLE.
REQ-021 Release and en_tick in the same clk SHALL resolve as release; no long or repeat pulse in that case.
REQ-022 Counters SHALL saturate at 255 and never wrap.
REQ-023 All outputs SHALL be registered; short, long and repeat pulses for one key SHALL be mutually exclusive in any clk.
REQ-024 key_held SHALL be 1 in PRESS and HOLD, 0 in IDLE and WAIT_REL.

Reset
REQ-025 While rst=0, all FSMs SHALL be IDLE, counters 0, previous-sample registers 1, and all outputs 0.
REQ-026 Reset asserted mid-press SHALL discard the press; no pulse SHALL be emitted for it after reset release.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit enum), the counter width (8) and the key count (4).
REQ-028 The per-key FSM and counter SHALL be one sub-module, key_event_cell, instantiated four times; the top SHALL contain only the instances and the any_event OR.

Verification (LONG_TICKS=5, REPEAT_TICKS=2, en_tick every 4 clk)
REQ-029 key_db[0] high for 3 ticks, then low -> short_pulse[0]=1 for one clk, one clk after the low sample; no long_pulse.
REQ-030 key_db[1] high for 10 ticks -> long_pulse[1] at tick 5, repeat_pulse[1] at ticks 7 and 9; no short_pulse on release.
REQ-031 key_db=4'b1111 held through reset release -> no pulses; after release to 0 and a new press of key 2 for 1 tick -> only short_pulse[2].
REQ-032 Key 3 released in the same clk as the 5th en_tick -> short_pulse[3] only; long_pulse[3] stays 0.
REQ-033 rst asserted at tick 4 of a key 0 press, released while still pressed -> all outputs 0; no event until release and re-press.
REQ-034 Keys 0 and 1 pressed together: key 0 for 2 ticks, key 1 for 6 ticks -> short_pulse[0], then long_pulse[1] at tick 5; any_event pulses exactly twice.
